sprite_regs_dbuf: RTL and testbench

- Parametrised successor of the game sprite register file.
- CPU side writes a shadow bank. The video/sprite engine reads an active bank over a separate registered port.
- Shadow is copied to active in one cycle at each frame strobe, unless the frame-lock register holds the commit off. This gives tear-free sprite updates.
- A read-only window exposes NUM_STATUS live status words (map data, desired rotation, frame count, pellet data, ...). The window is sampled each cycle.

---
 rtl/sprite_regs_dbuf_if.sv | 15 +
 rtl/sprite_regs_dbuf.sv | 128 ++++++++++++
 tb/tb_sprite_regs_dbuf.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sprite_regs_dbuf_if.sv
// CPU register bus for the sprite register file: address, write data/enable,
// combinational read data and the write-error pulse.
interface sprite_regs_dbuf_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] in;
  logic              we;
  logic [DATA_W-1:0] out;
  logic              wr_err;

  modport master (output reg_addr, output in, output we, input out, input wr_err);
  modport slave  (input reg_addr, input in, input we, output out, output wr_err);
endinterface

// File: rtl/sprite_regs_dbuf.sv
// Double-buffered sprite register file: the CPU fills a shadow bank, and the
// video engine reads an active bank that is refreshed from shadow at frame strobes.
//
// state  | meaning
// S_IDLE | no commit owed; an unlocked frame strobe commits immediately
// S_PEND | a strobe arrived while locked; commit as soon as the lock clears
module sprite_regs_dbuf #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 6,
  parameter int NUM_REGS    = 43,
  parameter int STATUS_BASE = 48,
  parameter int NUM_STATUS  = 4,
  parameter int LOCK_IDX    = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  sprite_regs_dbuf_if.slave            cpu,
  input  logic [NUM_STATUS*DATA_W-1:0] status_in,
  input  logic                         frame_strobe,
  input  logic [ADDR_W-1:0]            vid_addr,
  output logic [DATA_W-1:0]            vid_data,
  output logic                         commit_pending,
  output logic [7:0]                   commit_cnt
);

  typedef enum logic {S_IDLE, S_PEND} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_commit;
  logic              w_locked;

  logic [DATA_W-1:0] r_shadow [NUM_REGS];
  logic [DATA_W-1:0] r_active [NUM_REGS];
  logic [DATA_W-1:0] r_status [NUM_STATUS];
  logic [DATA_W-1:0] r_vid_data;
  logic              r_wr_err;
  logic [7:0]        r_commit_cnt;

  logic [NUM_REGS-1:0]   w_reg_hit;
  logic [NUM_STATUS-1:0] w_stat_hit;
  logic [NUM_REGS-1:0]   w_vid_hit;
  logic [DATA_W-1:0]     w_rd_data;
  logic [DATA_W-1:0]     w_vid_rd;

  always_comb begin
    w_reg_hit  = '0;
    w_stat_hit = '0;
    w_vid_hit  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_reg_hit[i] = (cpu.reg_addr == ADDR_W'(i));
      w_vid_hit[i] = (vid_addr == ADDR_W'(i));
    end
    for (int i = 0; i < NUM_STATUS; i++)
      w_stat_hit[i] = (cpu.reg_addr == ADDR_W'(STATUS_BASE + i));
  end

  // One-hot decode makes unmapped addresses fall through to zero.
  always_comb begin
    w_rd_data = '0;
    w_vid_rd  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_reg_hit[i]) w_rd_data = r_shadow[i];
      if (w_vid_hit[i]) w_vid_rd  = r_active[i];
    end
    for (int i = 0; i < NUM_STATUS; i++)
      if (w_stat_hit[i]) w_rd_data = r_status[i];
  end

  assign w_locked = r_shadow[LOCK_IDX][0];

  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_strobe) begin
          if (w_locked) w_state_nxt = S_PEND;
          else          w_commit    = 1'b1;
        end
      end
      S_PEND: begin
        if (!w_locked) begin
          w_commit    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Commit copies the pre-edge shadow, so a same-edge CPU write waits for the next commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      for (int i = 0; i < NUM_STATUS; i++) r_status[i] <= '0;
      r_vid_data   <= '0;
      r_wr_err     <= 1'b0;
      r_commit_cnt <= '0;
    end else begin
      r_vid_data <= w_vid_rd;
      r_wr_err   <= cpu.we & ~(|w_reg_hit);
      for (int i = 0; i < NUM_STATUS; i++)
        r_status[i] <= status_in[i*DATA_W +: DATA_W];
      for (int i = 0; i < NUM_REGS; i++)
        if (cpu.we && w_reg_hit[i]) r_shadow[i] <= cpu.in;
      if (w_commit) begin
        for (int i = 0; i < NUM_REGS; i++) r_active[i] <= r_shadow[i];
        r_commit_cnt <= r_commit_cnt + 8'd1;
      end
    end
  end

  assign cpu.out        = w_rd_data;
  assign cpu.wr_err     = r_wr_err;
  assign vid_data       = r_vid_data;
  assign commit_pending = (r_state == S_PEND);
  assign commit_cnt     = r_commit_cnt;

endmodule

// File: tb/tb_sprite_regs_dbuf.sv
// Directed bench for sprite_regs_dbuf: a bank-level reference model is compared
// against the DUT every cycle, plus literal checks that pin key scenarios.
module tb_sprite_regs_dbuf;
  localparam int DW = 16, AW = 6, NR = 43, SB = 48, NS = 4, LK = 32;

  logic clk = 1'b0;
  logic reset;
  logic [NS*DW-1:0] status_in;
  logic frame_strobe;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_data;
  logic commit_pending;
  logic [7:0] commit_cnt;

  sprite_regs_dbuf_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  sprite_regs_dbuf #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .STATUS_BASE(SB),
                     .NUM_STATUS(NS), .LOCK_IDX(LK)) dut (
    .clk(clk), .reset(reset), .cpu(bus.slave), .status_in(status_in),
    .frame_strobe(frame_strobe), .vid_addr(vid_addr), .vid_data(vid_data),
    .commit_pending(commit_pending), .commit_cnt(commit_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: two banks, a status snapshot and a boolean "commit owed".
  logic [DW-1:0] m_shadow [NR];
  logic [DW-1:0] m_active [NR];
  logic [DW-1:0] m_status [NS];
  logic [DW-1:0] m_vid;
  logic          m_wr_err;
  bit            m_owed;
  int            m_cnt;

  always @(posedge clk or negedge reset) begin
    bit locked, fire;
    if (!reset) begin
      for (int i = 0; i < NR; i++) begin m_shadow[i] = '0; m_active[i] = '0; end
      for (int i = 0; i < NS; i++) m_status[i] = '0;
      m_vid = '0; m_wr_err = 1'b0; m_owed = 1'b0; m_cnt = 0;
    end else begin
      locked = m_shadow[LK][0];
      fire   = !locked && (m_owed || frame_strobe);
      m_vid  = (int'(vid_addr) < NR) ? m_active[vid_addr] : '0;
      if (fire) begin
        m_active = m_shadow;
        m_cnt = (m_cnt + 1) % 256;
      end
      m_owed = locked && (m_owed || frame_strobe);
      m_wr_err = bus.we && (int'(bus.reg_addr) >= NR);
      if (bus.we && int'(bus.reg_addr) < NR) m_shadow[bus.reg_addr] = bus.in;
      for (int i = 0; i < NS; i++) m_status[i] = status_in[i*DW +: DW];
    end
  end

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (int'(a) < NR) return m_shadow[a];
    if (int'(a) >= SB && int'(a) < SB + NS) return m_status[int'(a) - SB];
    return '0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_out", 32'(bus.out), 32'(model_read(bus.reg_addr)));
      check("cyc_wr_err", 32'(bus.wr_err), 32'(m_wr_err));
      check("cyc_vid_data", 32'(vid_data), 32'(m_vid));
      check("cyc_pending", 32'(commit_pending), 32'(m_owed));
      check("cyc_commit_cnt", 32'(commit_cnt), 32'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.reg_addr = a; bus.in = d; bus.we = 1'b1;
    tick();
    bus.we = 1'b0;
  endtask

  task automatic strobe();
    frame_strobe = 1'b1;
    tick();
    frame_strobe = 1'b0;
  endtask

  initial begin
    logic [7:0] cnt0;
    reset = 1'b0; bus.reg_addr = '0; bus.in = '0; bus.we = 1'b0;
    status_in = '0; frame_strobe = 1'b0; vid_addr = '0;
    tick(); tick();
    check("rst_out", 32'(bus.out), 32'h0);
    check("rst_vid", 32'(vid_data), 32'h0);
    check("rst_cnt", 32'(commit_cnt), 32'h0);
    chk_en = 1'b1;
    reset = 1'b1;
    tick();

    // Shadow write without strobe stays invisible to video
    cpu_wr(6'd0, 16'h0123);
    bus.reg_addr = 6'd0; vid_addr = 6'd0;
    tick();
    check("shadow_rd0", 32'(bus.out), 32'h0123);
    check("vid_pre_commit", 32'(vid_data), 32'h0);
    check("cnt_pre_commit", 32'(commit_cnt), 32'h0);

    strobe();
    tick();
    check("vid_post_commit", 32'(vid_data), 32'h0123);
    check("cnt_one", 32'(commit_cnt), 32'h1);
    check("pend_zero", 32'(commit_pending), 32'h0);

    // Locked: two strobes collapse into one pending commit
    cpu_wr(6'd32, 16'h0001);
    cpu_wr(6'd8, 16'h00AA);
    vid_addr = 6'd8;
    strobe(); tick(); strobe(); tick();
    check("pend_locked", 32'(commit_pending), 32'h1);
    check("vid8_held", 32'(vid_data), 32'h0);
    cpu_wr(6'd32, 16'h0000);
    tick();
    tick();
    check("vid8_unlocked", 32'(vid_data), 32'h00AA);
    check("cnt_two", 32'(commit_cnt), 32'h2);
    check("pend_cleared", 32'(commit_pending), 32'h0);

    // Same-edge write and commit: active gets the pre-write value
    cpu_wr(6'd1, 16'h1111);
    strobe();
    vid_addr = 6'd1;
    bus.reg_addr = 6'd1; bus.in = 16'h5555; bus.we = 1'b1; frame_strobe = 1'b1;
    tick();
    bus.we = 1'b0; frame_strobe = 1'b0;
    tick();
    check("vid1_old", 32'(vid_data), 32'h1111);
    check("shadow1_new", 32'(bus.out), 32'h5555);
    strobe(); tick();
    check("vid1_new", 32'(vid_data), 32'h5555);
    check("cnt_five", 32'(commit_cnt), 32'h5);

    // Status window, read-only and unmapped addresses
    status_in[2*DW +: DW] = 16'h0039;
    status_in[3*DW +: DW] = 16'hBEEF;
    bus.reg_addr = 6'd50;
    tick();
    check("status2", 32'(bus.out), 32'h0039);
    cpu_wr(6'd50, 16'hFFFF);
    check("wr_err_pulse", 32'(bus.wr_err), 32'h1);
    check("status2_kept", 32'(bus.out), 32'h0039);
    tick();
    check("wr_err_clear", 32'(bus.wr_err), 32'h0);
    bus.reg_addr = 6'd45;
    #1 check("unmapped45", 32'(bus.out), 32'h0);
    cpu_wr(6'd42, 16'h4242);
    check("last_reg_no_err", 32'(bus.wr_err), 32'h0);
    bus.reg_addr = 6'd42;
    #1 check("last_reg_rd", 32'(bus.out), 32'h4242);
    cpu_wr(6'd43, 16'h4343);
    check("first_unmapped_err", 32'(bus.wr_err), 32'h1);
    bus.reg_addr = 6'd51;
    #1 check("status3", 32'(bus.out), 32'hBEEF);
    cpu_wr(6'd63, 16'h1234);
    check("top_addr_err", 32'(bus.wr_err), 32'h1);
    vid_addr = 6'd43;
    tick(); tick();
    check("vid_unmapped", 32'(vid_data), 32'h0);

    // Commit counter wraps after 256 commits
    cnt0 = commit_cnt;
    for (int i = 0; i < 256; i++) strobe();
    tick();
    check("cnt_wrap", 32'(commit_cnt), 32'(cnt0));

    // Reset while a commit is pending drops it
    vid_addr = 6'd0;
    cpu_wr(6'd32, 16'h0001);
    strobe(); tick();
    check("pend_before_rst", 32'(commit_pending), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("rst_pend", 32'(commit_pending), 32'h0);
    check("rst_vid_async", 32'(vid_data), 32'h0);
    check("rst_cnt_async", 32'(commit_cnt), 32'h0);
    tick(); tick();
    reset = 1'b1;
    bus.reg_addr = 6'd0;
    tick();
    check("post_rst_shadow0", 32'(bus.out), 32'h0);
    bus.reg_addr = 6'd32;
    #1 check("post_rst_lock", 32'(bus.out), 32'h0);
    tick(); tick();
    check("post_rst_pend", 32'(commit_pending), 32'h0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
